ifu_fetch: RTL

//  Instruction fetch stage directly upstream of exu_decode; owns the architectural PC.

---
 rtl/ifu_fetch.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch
//   Instruction fetch stage sitting directly in front of exu_decode. Owns the
//   architectural PC, issues one instruction-memory request at a time, latches
//   the returned word and hands it to decode over a valid/ready handshake.
//   Static prediction: JAL taken, backward B-type taken, everything else
//   (including JALR and forward branches) falls through to pc+4.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   ifu_req_valid  fetch request valid (only in the request state)
//   ifu_req_ready  memory accepts the request
//   ifu_req_addr   word-aligned fetch address (the current PC)
//   ifu_rsp_valid  one-cycle response pulse, always accepted
//   ifu_rsp_instr  returned instruction word
//   o_valid        instruction valid to decode
//   o_ready        decode accepts the instruction
//   o_instr        instruction word to decode (rv32_instr)
//   o_pc           PC of o_instr (i_pc)
//   o_prdt_taken   static prediction for o_instr (i_prdt_taken)
//   flush_req      redirect request from EXU, overrides everything else
//   flush_pc       redirect target, low two bits ignored
// ---------------------------------------------------------------------------
module ifu_fetch #(
  parameter int PC_SIZE    = 32,
  parameter int INSTR_SIZE = 32,
  parameter logic [PC_SIZE-1:0] RESET_PC = PC_SIZE'(32'h8000_0000)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ifu_req_valid,
  input  logic                  ifu_req_ready,
  output logic [PC_SIZE-1:0]    ifu_req_addr,
  input  logic                  ifu_rsp_valid,
  input  logic [INSTR_SIZE-1:0] ifu_rsp_instr,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [INSTR_SIZE-1:0] o_instr,
  output logic [PC_SIZE-1:0]    o_pc,
  output logic                  o_prdt_taken,
  input  logic                  flush_req,
  input  logic [PC_SIZE-1:0]    flush_pc
);

  localparam logic [2:0] ST_BOOT = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_OUT  = 3'd3;
  localparam logic [2:0] ST_DROP = 3'd4;

  localparam logic [INSTR_SIZE-1:0] NOP_INSTR = INSTR_SIZE'(32'h0000_0013);

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [PC_SIZE-1:0] pc;
  logic [PC_SIZE-1:0] flush_pc_aligned;
  logic [PC_SIZE-1:0] j_imm;
  logic [PC_SIZE-1:0] b_imm;
  logic [PC_SIZE-1:0] next_pc;
  logic               is_jal;
  logic               is_bwd_branch;
  logic               pred_taken;
  logic               rsp_accept;
  logic               unused_flush_lsb;

  assign unused_flush_lsb = ^flush_pc[1:0];
  assign flush_pc_aligned = {flush_pc[PC_SIZE-1:2], 2'b00};

  assign ifu_req_valid = (state == ST_REQ);
  assign ifu_req_addr  = pc;

  // A response is only turned into a decode instruction when we are waiting
  // for it and no redirect arrives in the same cycle.
  assign rsp_accept = (state == ST_WAIT) && ifu_rsp_valid && !flush_req;

  // Static prediction decoded straight from the returned word. Backward
  // branches are recognised by the sign bit of the B immediate.
  assign j_imm = {{(PC_SIZE-20){ifu_rsp_instr[31]}}, ifu_rsp_instr[19:12],
                  ifu_rsp_instr[20], ifu_rsp_instr[30:21], 1'b0};
  assign b_imm = {{(PC_SIZE-12){ifu_rsp_instr[31]}}, ifu_rsp_instr[7],
                  ifu_rsp_instr[30:25], ifu_rsp_instr[11:8], 1'b0};

  assign is_jal        = (ifu_rsp_instr[6:0] == 7'b1101111);
  assign is_bwd_branch = (ifu_rsp_instr[6:0] == 7'b1100011) && ifu_rsp_instr[31];
  assign pred_taken    = is_jal || is_bwd_branch;

  always_comb begin
    next_pc = pc + PC_SIZE'(4);
    if (is_jal) begin
      next_pc = pc + j_imm;
    end else if (is_bwd_branch) begin
      next_pc = pc + b_imm;
    end
  end

  // Next-state logic. A redirect always wins; the only question is whether a
  // request is still in flight whose response has to be swallowed in DROP.
  always_comb begin
    state_nxt = state;
    if (flush_req) begin
      case (state)
        ST_REQ:  state_nxt = ifu_req_ready ? ST_DROP : ST_REQ;
        ST_WAIT: state_nxt = ifu_rsp_valid ? ST_REQ : ST_DROP;
        ST_DROP: state_nxt = ifu_rsp_valid ? ST_REQ : ST_DROP;
        default: state_nxt = ST_REQ;
      endcase
    end else begin
      case (state)
        ST_BOOT: state_nxt = ST_REQ;
        ST_REQ:  state_nxt = ifu_req_ready ? ST_WAIT : ST_REQ;
        ST_WAIT: state_nxt = ifu_rsp_valid ? ST_OUT : ST_WAIT;
        ST_OUT:  state_nxt = o_ready ? ST_REQ : ST_OUT;
        ST_DROP: state_nxt = ifu_rsp_valid ? ST_REQ : ST_DROP;
        default: state_nxt = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // PC advances when a response is accepted; the predicted target is forced
  // word aligned so the fetch address never carries halfword bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (flush_req) begin
      pc <= flush_pc_aligned;
    end else if (rsp_accept) begin
      pc <= {next_pc[PC_SIZE-1:2], 2'b00};
    end
  end

  // Decode-side registers: loaded together from the response and held
  // untouched while decode stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_valid      <= 1'b0;
      o_instr      <= NOP_INSTR;
      o_pc         <= RESET_PC;
      o_prdt_taken <= 1'b0;
    end else if (flush_req) begin
      o_valid      <= 1'b0;
      o_prdt_taken <= 1'b0;
    end else if (rsp_accept) begin
      o_valid      <= 1'b1;
      o_instr      <= ifu_rsp_instr;
      o_pc         <= pc;
      o_prdt_taken <= pred_taken;
    end else if ((state == ST_OUT) && o_ready) begin
      o_valid      <= 1'b0;
    end
  end

endmodule
